// File: rtl/color_saturation_pipe.sv
// Two-stage YUV colour-saturation pipeline with frame-synchronous shadowed strengths
// and a per-frame clipped-pixel counter.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'h3
`endif

module color_saturation_pipe #(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned STRENGTH_WIDTH = 8,
   parameter int unsigned CLIP_COUNT_WIDTH = 16,
   parameter logic [`DTYPE_WIDTH-1:0] FRAME_START_DTYPE = `DTYPE_FRAME_START,
   parameter logic [`DTYPE_WIDTH-1:0] FRAME_END_DTYPE = `DTYPE_FRAME_END,
   parameter logic [`DTYPE_WIDTH-1:0] PIXEL_DTYPE = `DTYPE_PIXEL
) (
   input  logic                        clk,
   input  logic                        resetb,
   input  logic                        enable,
   input  logic [STRENGTH_WIDTH-1:0]   strength_u,
   input  logic [STRENGTH_WIDTH-1:0]   strength_v,
   input  logic                        dvi,
   input  logic [`DTYPE_WIDTH-1:0]     dtypei,
   input  logic [PIXEL_WIDTH-1:0]      yi,
   input  logic [PIXEL_WIDTH-1:0]      ui,
   input  logic [PIXEL_WIDTH-1:0]      vi,
   input  logic [15:0]                 meta_datai,
   output logic                        dvo,
   output logic [`DTYPE_WIDTH-1:0]     dtypeo,
   output logic [PIXEL_WIDTH-1:0]      yo,
   output logic [PIXEL_WIDTH-1:0]      uo,
   output logic [PIXEL_WIDTH-1:0]      vo,
   output logic [15:0]                 meta_datao,
   output logic [CLIP_COUNT_WIDTH-1:0] clip_count,
   output logic                        clip_count_valid
);

   localparam int unsigned P  = PIXEL_WIDTH;
   localparam int unsigned S  = STRENGTH_WIDTH;
   localparam int unsigned GW = S + 2;
   localparam int unsigned W  = P + S + 10;

   localparam logic signed [W-1:0] C_MAX = W'((1 << (P - 1)) - 1);
   localparam logic signed [W-1:0] C_MIN = -C_MAX - W'(1);
   localparam logic signed [W-1:0] Y_MAX = W'((1 << P) - 1);
   localparam logic signed [W-1:0] C89   = W'(89);
   localparam logic signed [W-1:0] C43   = W'(43);

   // Active (shadowed) configuration
   logic                act_en;
   logic [S-1:0]        act_su;
   logic [S-1:0]        act_sv;

   logic                is_fs;
   logic                is_fe;
   logic                eff_en;
   logic [S-1:0]        eff_su;
   logic [S-1:0]        eff_sv;
   logic [GW-1:0]       gu;
   logic [GW-1:0]       gv;
   logic signed [W-1:0] ui_s;
   logic signed [W-1:0] vi_s;
   logic signed [W-1:0] pu_d;
   logic signed [W-1:0] pv_d;
   logic signed [W-1:0] py_d;
   logic signed [W-1:0] pyu_d;
   logic signed [W-1:0] pyv_d;
   logic                proc_d;

   // Stage 1 registers
   logic                s1_dv;
   logic [`DTYPE_WIDTH-1:0] s1_dtype;
   logic [15:0]         s1_meta;
   logic [P-1:0]        s1_y;
   logic [P-1:0]        s1_u;
   logic [P-1:0]        s1_v;
   logic                s1_proc;
   logic                s1_fs;
   logic                s1_fe;
   logic signed [W-1:0] s1_pu;
   logic signed [W-1:0] s1_pv;
   logic signed [W-1:0] s1_py;
   logic signed [W-1:0] s1_pyu;
   logic signed [W-1:0] s1_pyv;

   logic signed [W-1:0] u_sh;
   logic signed [W-1:0] v_sh;
   logic signed [W-1:0] y_sh;
   logic [P-1:0]        y_d;
   logic [P-1:0]        u_d;
   logic [P-1:0]        v_d;
   logic                clip;
   logic [CLIP_COUNT_WIDTH-1:0] run_cnt;
   logic [CLIP_COUNT_WIDTH-1:0] cnt_base;
   logic [CLIP_COUNT_WIDTH-1:0] cnt_inc;

   // The frame-start beat itself already uses the newly sampled configuration.
   always_comb begin
      is_fs  = dvi && (dtypei == FRAME_START_DTYPE);
      is_fe  = dvi && (dtypei == FRAME_END_DTYPE);
      eff_en = is_fs ? enable : act_en;
      eff_su = is_fs ? strength_u : act_su;
      eff_sv = is_fs ? strength_v : act_sv;
      proc_d = dvi && (dtypei == PIXEL_DTYPE) && eff_en;
      gu     = {2'b01, {S{1'b0}}} + GW'(eff_su) * GW'(3);
      gv     = {2'b01, {S{1'b0}}} + GW'(eff_sv) * GW'(3);
      ui_s   = W'(signed'(ui));
      vi_s   = W'(signed'(vi));
      pu_d   = ui_s * signed'(W'(gu));
      pv_d   = vi_s * signed'(W'(gv));
      py_d   = signed'(W'(yi) << (S + 6));
      pyu_d  = ui_s * signed'(W'(eff_su)) * C89;
      pyv_d  = vi_s * signed'(W'(eff_sv)) * C43;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         act_en   <= 1'b0;
         act_su   <= '0;
         act_sv   <= '0;
         s1_dv    <= 1'b0;
         s1_dtype <= '0;
         s1_meta  <= '0;
         s1_y     <= '0;
         s1_u     <= '0;
         s1_v     <= '0;
         s1_proc  <= 1'b0;
         s1_fs    <= 1'b0;
         s1_fe    <= 1'b0;
         s1_pu    <= '0;
         s1_pv    <= '0;
         s1_py    <= '0;
         s1_pyu   <= '0;
         s1_pyv   <= '0;
      end else begin
         if (is_fs) begin
            act_en <= enable;
            act_su <= strength_u;
            act_sv <= strength_v;
         end
         s1_dv    <= dvi;
         s1_dtype <= dtypei;
         s1_meta  <= meta_datai;
         s1_y     <= yi;
         s1_u     <= ui;
         s1_v     <= vi;
         s1_proc  <= proc_d;
         s1_fs    <= is_fs;
         s1_fe    <= is_fe;
         s1_pu    <= pu_d;
         s1_pv    <= pv_d;
         s1_py    <= py_d;
         s1_pyu   <= pyu_d;
         s1_pyv   <= pyv_d;
      end
   end

   always_comb begin
      u_sh = s1_pu >>> S;
      v_sh = s1_pv >>> S;
      y_sh = (s1_py - s1_pyu - s1_pyv) >>> (S + 6);
      clip = 1'b0;
      y_d  = s1_y;
      u_d  = s1_u;
      v_d  = s1_v;
      if (s1_proc) begin
         if (u_sh > C_MAX) begin
            u_d  = P'(C_MAX);
            clip = 1'b1;
         end else if (u_sh < C_MIN) begin
            u_d  = P'(C_MIN);
            clip = 1'b1;
         end else begin
            u_d = P'(u_sh);
         end
         if (v_sh > C_MAX) begin
            v_d  = P'(C_MAX);
            clip = 1'b1;
         end else if (v_sh < C_MIN) begin
            v_d  = P'(C_MIN);
            clip = 1'b1;
         end else begin
            v_d = P'(v_sh);
         end
         if (y_sh > Y_MAX) begin
            y_d  = P'(Y_MAX);
            clip = 1'b1;
         end else if (y_sh < 0) begin
            y_d  = '0;
            clip = 1'b1;
         end else begin
            y_d = P'(y_sh);
         end
      end
      cnt_base = s1_fs ? '0 : run_cnt;
      cnt_inc  = (clip && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         dvo              <= 1'b0;
         dtypeo           <= '0;
         meta_datao       <= '0;
         yo               <= '0;
         uo               <= '0;
         vo               <= '0;
         run_cnt          <= '0;
         clip_count       <= '0;
         clip_count_valid <= 1'b0;
      end else begin
         dvo              <= s1_dv;
         dtypeo           <= s1_dtype;
         meta_datao       <= s1_meta;
         yo               <= y_d;
         uo               <= u_d;
         vo               <= v_d;
         run_cnt          <= s1_fe ? '0 : cnt_inc;
         clip_count_valid <= s1_fe;
         if (s1_fe) begin
            clip_count <= cnt_inc;
         end
      end
   end

endmodule
